// File: rtl/window_rotate_seq_if.sv
// Handshake bundle for window_rotate_seq: window/angle request in, sample beats out.
// The master drives the request and out_ready; the slave (the sampler) drives the rest.
interface window_rotate_seq_if #(
  parameter int unsigned WIN_W  = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = DATA_W,
  parameter int unsigned LANES  = 1
);
  localparam int unsigned N    = WIN_W * WIN_W;
  localparam int unsigned IdxW = $clog2(N);

  logic                   in_valid;
  logic                   in_ready;
  logic [N*DATA_W-1:0]    in_window;
  logic [5:0]             in_angle;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [IdxW-1:0]        out_idx;
  logic [LANES-1:0]       out_mask;
  logic                   out_last;
  logic                   angle_err;

  modport master (
    output in_valid, in_window, in_angle, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_mask, out_last, angle_err
  );

  modport slave (
    input  in_valid, in_window, in_angle, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_mask, out_last, angle_err
  );
endinterface

// File: rtl/window_rotate_seq.sv
// Time-multiplexed rotated/scaled bilinear window sampler, LANES samples per beat.
// Define WINROT_FULL360_EN for 0..350 deg angles; otherwise only 0..80 deg are accepted.
module window_rotate_seq #(
  parameter int unsigned WIN_W       = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OUT_W       = DATA_W,
  parameter int unsigned INTERP_BITS = 4,
  parameter int unsigned LANES       = 1,
  parameter int unsigned SCALE       = 15565
) (
  input logic                clk,
  input logic                rst_n,
  input logic                en,
  window_rotate_seq_if.slave bus
);
  localparam int unsigned N    = WIN_W * WIN_W;
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(N + LANES) + 1;
  localparam int          Win  = int'(WIN_W);
  localparam int          Ctr  = (Win - 1) / 2;
  localparam int unsigned Sh   = INTERP_BITS + DATA_W - OUT_W;
  localparam logic [63:0] One  = 64'(1) << INTERP_BITS;
`ifdef WINROT_FULL360_EN
  localparam int unsigned MaxAngle = 35;
`else
  localparam int unsigned MaxAngle = 8;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef struct packed {
    logic                         ok;
    logic [INTERP_BITS-1:0]       fx;
    logic [INTERP_BITS-1:0]       fy;
    logic [3:0][DATA_W-1:0]       nb;
  } samp_t;

  // round(2^14 * sin(k * 10 deg)); cos(k) is read as sin(9 - k)
  function automatic logic [14:0] sin_lut(input logic [3:0] k);
    case (k)
      4'd1:    sin_lut = 15'd2845;
      4'd2:    sin_lut = 15'd5604;
      4'd3:    sin_lut = 15'd8192;
      4'd4:    sin_lut = 15'd10531;
      4'd5:    sin_lut = 15'd12551;
      4'd6:    sin_lut = 15'd14189;
      4'd7:    sin_lut = 15'd15396;
      4'd8:    sin_lut = 15'd16135;
      4'd9:    sin_lut = 15'd16384;
      default: sin_lut = 15'd0;
    endcase
  endfunction

  // A neighbour only has to be inside the window when its weight is non-zero, so exact
  // integer source coordinates on the last row/column still sample.
  function automatic samp_t fetch(input int pk, input logic [N*DATA_W-1:0] win,
                                  input int cs, input int sn, input logic byp);
    samp_t s;
    int gx, gy, xs, ys, lx, ly, ex, ey;
    s  = '0;
    gx = pk % Win;
    gy = pk / Win;
    if (byp) begin
      xs = gx <<< 14;
      ys = gy <<< 14;
    end else begin
      xs = (gx - Ctr) * cs - (gy - Ctr) * sn + (Ctr <<< 14);
      ys = (gx - Ctr) * sn + (gy - Ctr) * cs + (Ctr <<< 14);
    end
    lx   = xs >>> 14;
    ly   = ys >>> 14;
    s.fx = xs[13 -: INTERP_BITS];
    s.fy = ys[13 -: INTERP_BITS];
    ex   = (s.fx != '0) ? 1 : 0;
    ey   = (s.fy != '0) ? 1 : 0;
    s.ok = (pk < int'(N)) && (lx >= 0) && (ly >= 0) && (lx + ex < Win) && (ly + ey < Win);
    if (s.ok) begin
      s.nb[0] = win[(ly * Win + lx) * DATA_W +: DATA_W];
      if (ex != 0) s.nb[1] = win[(ly * Win + lx + 1) * DATA_W +: DATA_W];
      if (ey != 0) s.nb[2] = win[((ly + 1) * Win + lx) * DATA_W +: DATA_W];
      if (ex != 0 && ey != 0) s.nb[3] = win[((ly + 1) * Win + lx + 1) * DATA_W +: DATA_W];
    end
    return s;
  endfunction

  function automatic logic [OUT_W-1:0] interp(input samp_t s);
    logic [63:0] ix0, ix1, acc;
    ix0 = (64'(s.nb[0]) * (One - 64'(s.fx)) + 64'(s.nb[1]) * 64'(s.fx)) >> INTERP_BITS;
    ix1 = (64'(s.nb[2]) * (One - 64'(s.fx)) + 64'(s.nb[3]) * 64'(s.fx)) >> INTERP_BITS;
    acc = (ix0 * (One - 64'(s.fy)) + ix1 * 64'(s.fy)) >> Sh;
    return s.ok ? OUT_W'(acc) : '0;
  endfunction

  state_e                      state_q, state_d;
  logic [N*DATA_W-1:0]         win_q;
  logic signed [17:0]          cos_q, sin_q;
  logic                        bypass_q, angle_err_q;
  logic [CntW-1:0]             p_q;
  samp_t [LANES-1:0]           s1_d, s1_q;
  logic [LANES-1:0]            mask_d, s1_mask_q, s2_mask_q;
  logic                        s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
  logic [IdxW-1:0]             s1_idx_q, s2_idx_q;
  logic [LANES-1:0][OUT_W-1:0] data_d, s2_data_q;

  logic        angle_bad;
  logic [5:0]  angle_eff;
  logic [1:0]  quad;
  int unsigned trig_r, cos_mag, sin_mag;
  int          cos_i, sin_i;

  // Quadrant folding: rotate the first-quadrant pair by quad * 90 deg.
  always_comb begin
    angle_bad = bus.in_angle > 6'(MaxAngle);
    angle_eff = angle_bad ? 6'd0 : bus.in_angle;
`ifdef WINROT_FULL360_EN
    quad   = 2'(angle_eff / 6'd9);
    trig_r = 32'(angle_eff % 6'd9);
`else
    quad   = 2'd0;
    trig_r = 32'(angle_eff);
`endif
    cos_mag = (32'(sin_lut(4'(9 - trig_r))) * SCALE) >> 14;
    sin_mag = (32'(sin_lut(4'(trig_r))) * SCALE) >> 14;
    cos_i   = int'(cos_mag);
    sin_i   = int'(sin_mag);
    unique case (quad)
      2'd1: begin cos_i = -int'(sin_mag); sin_i =  int'(cos_mag); end
      2'd2: begin cos_i = -int'(cos_mag); sin_i = -int'(sin_mag); end
      2'd3: begin cos_i =  int'(sin_mag); sin_i = -int'(cos_mag); end
      default: ;
    endcase
  end

  logic accept, issue, stall, adv, last_acc;
  assign accept   = en && bus.in_valid && (state_q == StIdle);
  assign issue    = (state_q == StRun) && (p_q < CntW'(N));
  assign stall    = s2_valid_q && !bus.out_ready;
  assign adv      = en && !stall;
  assign last_acc = en && s2_valid_q && bus.out_ready && s2_last_q;

  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      s1_d[k]   = fetch(int'(p_q) + k, win_q, int'(cos_q), int'(sin_q), bypass_q);
      mask_d[k] = (int'(p_q) + k) < int'(N);
      data_d[k] = interp(s1_q[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_acc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      win_q       <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      bypass_q    <= 1'b0;
      angle_err_q <= 1'b0;
      p_q         <= '0;
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_mask_q   <= '0;
      s1_last_q   <= 1'b0;
      s2_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_idx_q    <= '0;
      s2_mask_q   <= '0;
      s2_last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q       <= bus.in_window;
        cos_q       <= 18'(cos_i);
        sin_q       <= 18'(sin_i);
        bypass_q    <= (angle_eff == 6'd0);
        angle_err_q <= angle_bad;
        p_q         <= '0;
      end else if (issue && adv) begin
        p_q <= p_q + CntW'(LANES);
      end
      if (adv) begin
        s1_valid_q <= issue;
        if (issue) begin
          s1_q      <= s1_d;
          s1_idx_q  <= IdxW'(p_q);
          s1_mask_q <= mask_d;
          s1_last_q <= (int'(p_q) + int'(LANES)) >= int'(N);
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= data_d;
          s2_idx_q  <= s1_idx_q;
          s2_mask_q <= s1_mask_q;
          s2_last_q <= s1_last_q;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_idx   = s2_idx_q;
  assign bus.out_mask  = s2_mask_q;
  assign bus.out_last  = s2_last_q;
  assign bus.angle_err = angle_err_q;
endmodule

// File: tb/tb_window_rotate_seq.sv
// Directed bench for window_rotate_seq: a LANES=1 and a LANES=4 instance at unity scale.
module tb_window_rotate_seq;
  localparam int N = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   exp_data [N];
  logic exp_err;

  window_rotate_seq_if #(.WIN_W(5), .DATA_W(8), .OUT_W(8), .LANES(1)) b1 ();
  window_rotate_seq_if #(.WIN_W(5), .DATA_W(8), .OUT_W(8), .LANES(4)) b4 ();

  window_rotate_seq #(.WIN_W(5), .DATA_W(8), .OUT_W(8), .INTERP_BITS(4), .LANES(1),
                      .SCALE(16384)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .bus(b1));
  window_rotate_seq #(.WIN_W(5), .DATA_W(8), .OUT_W(8), .INTERP_BITS(4), .LANES(4),
                      .SCALE(16384)) u4 (.clk(clk), .rst_n(rst_n), .en(en), .bus(b4));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] ramp(input int mul);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[i*8 +: 8] = 8'(i * mul);
    return w;
  endfunction

  task automatic start1(input logic [5:0] ang, input logic [199:0] w);
    b1.in_window = w;
    b1.in_angle  = ang;
    b1.in_valid  = 1'b1;
    check("in_ready_idle", 32'(b1.in_ready), 32'd1);
    step();
    b1.in_valid = 1'b0;
    check("in_ready_busy", 32'(b1.in_ready), 32'd0);
    step();
    check("latency_t1", 32'(b1.out_valid), 32'd0);
    step();
    check("latency_t2", 32'(b1.out_valid), 32'd1);
  endtask

  task automatic drain1(input int stall_at, input logic err);
    for (int i = 0; i < N; i++) begin
      int guard = 0;
      while (!b1.out_valid && guard < 10) begin
        step();
        guard++;
      end
      check("beat_valid", 32'(b1.out_valid), 32'd1);
      check("beat_idx", 32'(b1.out_idx), 32'(i));
      if (exp_data[i] >= 0) check("beat_data", 32'(b1.out_data), 32'(exp_data[i]));
      check("beat_last", 32'(b1.out_last), 32'(i == N - 1));
      if (i == stall_at) begin
        b1.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          check("hold_valid", 32'(b1.out_valid), 32'd1);
          check("hold_idx", 32'(b1.out_idx), 32'(i));
          check("hold_data", 32'(b1.out_data), 32'(exp_data[i]));
        end
        b1.out_ready = 1'b1;
      end
      step();
    end
    check("done_valid", 32'(b1.out_valid), 32'd0);
    check("done_in_ready", 32'(b1.in_ready), 32'd1);
    check("angle_err", 32'(b1.angle_err), 32'(err));
  endtask

  initial begin
    b1.in_valid = 1'b0; b1.in_angle = '0; b1.in_window = '0; b1.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.in_angle = '0; b4.in_window = '0; b4.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(b1.in_ready), 32'd1);
    check("rst_out_valid", 32'(b1.out_valid), 32'd0);
    check("rst_out_data", 32'(b1.out_data), 32'd0);
    check("rst_out_idx", 32'(b1.out_idx), 32'd0);
    check("rst_out_mask", 32'(b4.out_mask), 32'd0);
    check("rst_out_last", 32'(b1.out_last), 32'd0);
    check("rst_angle_err", 32'(b1.angle_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Angle 0: identity bypass
    for (int i = 0; i < N; i++) exp_data[i] = i;
    start1(6'd0, ramp(1));
    drain1(-1, 1'b0);

    // Angle 18: 180 deg with full range, otherwise out of range -> identity plus error
`ifdef WINROT_FULL360_EN
    for (int i = 0; i < N; i++) exp_data[i] = 24 - i;
    exp_err = 1'b0;
`else
    for (int i = 0; i < N; i++) exp_data[i] = i;
    exp_err = 1'b1;
`endif
    start1(6'd18, ramp(1));
    drain1(-1, exp_err);

`ifdef WINROT_FULL360_EN
    // Angle 9 (90 deg): out(gx,gy) = in(4-gy, gx)
    for (int i = 0; i < N; i++) exp_data[i] = (i % 5) * 5 + 4 - (i / 5);
    start1(6'd9, ramp(1));
    drain1(-1, 1'b0);
`endif

    // Angle 4 (40 deg), pixel i = 10*i: corners fall outside, interior interpolates
    for (int i = 0; i < N; i++) exp_data[i] = -1;
    exp_data[0]  = 0;
    exp_data[7]  = 85;
    exp_data[12] = 120;
    exp_data[24] = 0;
    start1(6'd4, ramp(10));
    drain1(-1, 1'b0);

    // Backpressure on beat 3
    for (int i = 0; i < N; i++) exp_data[i] = i;
    start1(6'd0, ramp(1));
    drain1(3, 1'b0);

    // LANES=4: seven beats, final beat holds only pixel 24
    b4.in_window = ramp(1);
    b4.in_angle  = 6'd0;
    b4.in_valid  = 1'b1;
    step();
    b4.in_valid = 1'b0;
    step();
    check("l4_latency_t1", 32'(b4.out_valid), 32'd0);
    step();
    for (int b = 0; b < 7; b++) begin
      logic [31:0] ed;
      logic [3:0]  em;
      ed = '0;
      em = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * b + k < N) begin
          ed[k*8 +: 8] = 8'(4 * b + k);
          em[k]        = 1'b1;
        end
      end
      check("l4_valid", 32'(b4.out_valid), 32'd1);
      check("l4_idx", 32'(b4.out_idx), 32'(4 * b));
      check("l4_data", b4.out_data, ed);
      check("l4_mask", 32'(b4.out_mask), 32'(em));
      check("l4_last", 32'(b4.out_last), 32'(b == 6));
      step();
    end
    check("l4_done_valid", 32'(b4.out_valid), 32'd0);
    check("l4_done_in_ready", 32'(b4.in_ready), 32'd1);

    // Reset in the middle of a job
    start1(6'd0, ramp(1));
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(b1.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(b1.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(b1.out_data), 32'd0);
    check("mid_rst_out_idx", 32'(b1.out_idx), 32'd0);
    check("mid_rst_out_last", 32'(b1.out_last), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_out_valid", 32'(b1.out_valid), 32'd0);
    check("post_rst_in_ready", 32'(b1.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
